// File: rtl/h_scrubber_16_11.sv
// Background scrub controller for a Hamming(16,11) SECDED memory, with its decoder.
// Walks every address, writes back single-bit fixes and logs uncorrectable words.

module h_decoder_16_11 (
   input  logic [15:0] code,
   output logic [10:0] data,
   output logic        error_c,
   output logic        error_d
);
   logic [3:0]  syndrome;
   logic        parity;
   logic [15:0] fixed;

   // Syndrome is the XOR of the positions of all set bits; overall parity splits single/double
   always_comb begin
      syndrome = 4'd0;
      for (int i = 1; i < 16; i++) begin
         if (code[i]) syndrome = syndrome ^ 4'(i);
      end
      parity = ^code;
      fixed  = code;
      if (parity && (syndrome != 4'd0)) fixed[syndrome] = ~code[syndrome];
      error_c = parity;
      error_d = !parity && (syndrome != 4'd0);
      data    = {fixed[15:9], fixed[7:5], fixed[3]};
   end
endmodule

module h_scrubber_16_11 #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              i_Start,
   input  logic              i_Abort,
   output logic              o_MemReq,
   input  logic              i_MemGnt,
   output logic              o_MemRd,
   output logic              o_MemWr,
   output logic [ADDR_W-1:0] o_MemAddr,
   input  logic [15:0]       i_MemRdata,
   output logic [15:0]       o_MemWdata,
   output logic              o_Busy,
   output logic              o_Done,
   output logic [CNT_W-1:0]  o_CorrCnt,
   output logic [CNT_W-1:0]  o_UncorrCnt,
   output logic              o_ErrValid,
   output logic [ADDR_W-1:0] o_ErrAddr
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WR_REQ, S_NEXT, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       capture_q;
   logic [15:0]       wdata_q;
   logic [CNT_W-1:0]  corr_q, uncorr_q;
   logic              err_valid_q;
   logic [ADDR_W-1:0] err_addr_q;
   logic              abort_q;

   logic [10:0]       dec_data;
   logic              dec_err_c, dec_err_d;

   h_decoder_16_11 u_dec (
      .code    (capture_q),
      .data    (dec_data),
      .error_c (dec_err_c),
      .error_d (dec_err_d)
   );

   function automatic logic [15:0] encode(input logic [10:0] d);
      logic [15:0] cw;
      cw       = 16'd0;
      cw[15:9] = d[10:4];
      cw[7:5]  = d[3:1];
      cw[3]    = d[0];
      cw[1]    = ^{cw[3], cw[5], cw[7], cw[9], cw[11], cw[13], cw[15]};
      cw[2]    = ^{cw[3], cw[6], cw[7], cw[10], cw[11], cw[14], cw[15]};
      cw[4]    = ^{cw[5], cw[6], cw[7], cw[12], cw[13], cw[14], cw[15]};
      cw[8]    = ^cw[15:9];
      cw[0]    = ^cw[15:1];
      return cw;
   endfunction

   // Next-state and memory handshake; strobes follow the grant combinationally
   always_comb begin
      state_d  = state_q;
      o_MemReq = 1'b0;
      o_MemRd  = 1'b0;
      o_MemWr  = 1'b0;
      case (state_q)
         S_IDLE:    if (i_Start) state_d = S_RD_REQ;
         S_RD_REQ: begin
            o_MemReq = 1'b1;
            o_MemRd  = i_MemGnt;
            if (i_MemGnt) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: state_d = S_CHECK;
         S_CHECK:   state_d = dec_err_c ? S_WR_REQ : S_NEXT;
         S_WR_REQ: begin
            o_MemReq = 1'b1;
            o_MemWr  = i_MemGnt;
            if (i_MemGnt) state_d = S_NEXT;
         end
         S_NEXT:    state_d = (abort_q || (addr_q == LAST_ADDR)) ? S_DONE : S_RD_REQ;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      // A reset arriving mid-access must not let a half-finished write reach memory
      if (!i_Rst_n) begin
         o_MemReq = 1'b0;
         o_MemRd  = 1'b0;
         o_MemWr  = 1'b0;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         capture_q   <= 16'd0;
         wdata_q     <= 16'd0;
         corr_q      <= '0;
         uncorr_q    <= '0;
         err_valid_q <= 1'b0;
         err_addr_q  <= '0;
         abort_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_IDLE)
            abort_q <= 1'b0;
         else if ((state_q != S_IDLE) && i_Abort)
            abort_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (i_Start) begin
                  addr_q      <= '0;
                  corr_q      <= '0;
                  uncorr_q    <= '0;
                  err_valid_q <= 1'b0;
                  err_addr_q  <= '0;
               end
            end
            S_RD_WAIT: capture_q <= i_MemRdata;
            S_CHECK: begin
               if (dec_err_c) begin
                  if (corr_q != CNT_MAX) corr_q <= corr_q + CNT_W'(1);
                  wdata_q <= encode(dec_data);
               end else if (dec_err_d) begin
                  if (uncorr_q != CNT_MAX) uncorr_q <= uncorr_q + CNT_W'(1);
                  err_addr_q  <= addr_q;
                  err_valid_q <= 1'b1;
               end
            end
            S_NEXT: if (state_d == S_RD_REQ) addr_q <= addr_q + ADDR_W'(1);
            default: ;
         endcase
      end
   end

   assign o_MemAddr   = addr_q;
   assign o_MemWdata  = wdata_q;
   assign o_Busy      = (state_q != S_IDLE);
   assign o_Done      = (state_q == S_DONE);
   assign o_CorrCnt   = corr_q;
   assign o_UncorrCnt = uncorr_q;
   assign o_ErrValid  = err_valid_q;
   assign o_ErrAddr   = err_addr_q;
endmodule

// File: tb/tb_h_scrubber_16_11.sv
// Self-checking bench for h_scrubber_16_11: a memory model, a grant generator and a
// word-level reference model derived from how many bits each stored word has flipped.

module tb_h_scrubber_16_11;
   localparam int unsigned ADDR_W  = 3;
   localparam int unsigned DEPTH   = 6;
   localparam int unsigned CNT_W   = 2;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;
   localparam int          BUDGET  = 2000;

   logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, gnt = 1'b1;
   logic              mem_req, mem_rd, mem_wr, busy, done, err_valid;
   logic [ADDR_W-1:0] mem_addr, err_addr;
   logic [15:0]       rdata = 16'd0, wdata;
   logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;

   int n_checks = 0, n_fails = 0;
   int gnt_mode = 0;   // 0: always granted, 1: random, 2: withheld 3 cycles per request
   int req_age  = 0;

   logic [15:0] mem    [DEPTH];
   logic [15:0] clean  [DEPTH];
   logic [15:0] stored [DEPTH];
   int          nflip  [DEPTH];

   bit          log_wr   [$];
   int          log_addr [$];
   logic [15:0] log_data [$];
   logic              pend_rd = 1'b0, pend_wr = 1'b0, prev_stall = 1'b0;
   logic [ADDR_W-1:0] pend_addr = '0, prev_addr = '0;
   logic [15:0]       pend_data = 16'd0;

   h_scrubber_16_11 #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Abort(abort),
      .o_MemReq(mem_req), .i_MemGnt(gnt), .o_MemRd(mem_rd), .o_MemWr(mem_wr),
      .o_MemAddr(mem_addr), .i_MemRdata(rdata), .o_MemWdata(wdata),
      .o_Busy(busy), .o_Done(done), .o_CorrCnt(corr_cnt), .o_UncorrCnt(uncorr_cnt),
      .o_ErrValid(err_valid), .o_ErrAddr(err_addr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference encoder: data fills the non-power-of-two positions, parity p covers positions with bit p set
   function automatic logic [15:0] ref_encode(input logic [10:0] d);
      logic [15:0] cw;
      logic        par;
      int          k;
      cw = 16'd0;
      k  = 0;
      for (int pos = 1; pos < 16; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = d[k];
            k++;
         end
      end
      for (int p = 1; p < 16; p = p * 2) begin
         par = 1'b0;
         for (int pos = 1; pos < 16; pos++)
            if (((pos & p) != 0) && (pos != p)) par = par ^ cw[pos];
         cw[p] = par;
      end
      cw[0] = ^cw[15:1];
      return cw;
   endfunction

   task automatic set_word(input int i, input int nf, input int b0, input int b1);
      logic [10:0] d;
      d         = 11'($urandom);
      clean[i]  = ref_encode(d);
      stored[i] = clean[i];
      if (nf >= 1) stored[i][b0] = ~stored[i][b0];
      if (nf >= 2) stored[i][b1] = ~stored[i][b1];
      nflip[i] = nf;
      mem[i]   = stored[i];
   endtask

   task automatic set_rand(input int i);
      int b0;
      b0 = $urandom_range(0, 15);
      set_word(i, $urandom_range(0, 2), b0, (b0 + $urandom_range(1, 15)) % 16);
   endtask

   // Memory side: capture strobes mid-cycle, act on them at the clock edge
   always @(negedge clk) begin
      pend_rd   = mem_rd;
      pend_wr   = mem_wr;
      pend_addr = mem_addr;
      pend_data = wdata;
      if (mem_rd || mem_wr) begin
         check("strobe_grant", {30'd0, mem_req, gnt}, 32'd3);
         log_wr.push_back(mem_wr);
         log_addr.push_back(int'(mem_addr));
         log_data.push_back(mem_wr ? wdata : 16'd0);
      end
      if (prev_stall && rst_n) begin
         check("stall_req", {31'd0, mem_req}, 32'd1);
         check("stall_addr", {29'd0, mem_addr}, {29'd0, prev_addr});
      end
      prev_stall = mem_req && !gnt;
      prev_addr  = mem_addr;
   end

   always @(posedge clk) begin
      if (pend_rd) rdata <= mem[pend_addr];
      if (pend_wr) mem[pend_addr] = pend_data;
   end

   always @(posedge clk) begin
      #1;
      req_age = mem_req ? req_age + 1 : 0;
      case (gnt_mode)
         0:       gnt = 1'b1;
         1:       gnt = ($urandom_range(0, 99) < 60);
         default: gnt = (req_age > 3);
      endcase
   end

   task automatic run_pass(input string name, input int abort_word, input int restart_cyc);
      int          last_w, exp_cyc, abort_cyc, n, e_corr, e_unc, e_ea, e_ev;
      logic [31:0] exp_log [$];
      logic [15:0] exp_mem;
      last_w    = (abort_word >= 0) ? abort_word : int'(DEPTH) - 1;
      exp_cyc   = 1;
      abort_cyc = -1;
      e_corr = 0; e_unc = 0; e_ea = 0; e_ev = 0;
      for (int i = 0; i <= last_w; i++) begin
         if (i == abort_word) abort_cyc = exp_cyc + 2;
         exp_cyc += (nflip[i] == 1) ? 5 : 4;
         exp_log.push_back({7'd0, 1'b0, 8'(i), 16'd0});
         if (nflip[i] == 1) begin
            exp_log.push_back({7'd0, 1'b1, 8'(i), clean[i]});
            e_corr++;
         end
         if (nflip[i] == 2) begin
            e_unc++;
            e_ev = 1;
            e_ea = i;
         end
      end
      if (e_corr > CNT_MAX) e_corr = CNT_MAX;
      if (e_unc > CNT_MAX) e_unc = CNT_MAX;

      log_wr.delete(); log_addr.delete(); log_data.delete();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (n < BUDGET) begin
         @(negedge clk);
         n++;
         abort = (n == abort_cyc);
         start = (n == restart_cyc);
         if (n == 1) check({name, "_busy"}, {31'd0, busy}, 32'd1);
         if (done) break;
      end
      abort = 1'b0;
      start = 1'b0;
      check({name, "_done_seen"}, {31'd0, done}, 32'd1);
      if (gnt_mode == 0) check({name, "_done_cycle"}, n, exp_cyc);
      @(negedge clk);
      check({name, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({name, "_idle"}, {31'd0, busy}, 32'd0);
      check({name, "_corr"}, {30'd0, corr_cnt}, e_corr);
      check({name, "_uncorr"}, {30'd0, uncorr_cnt}, e_unc);
      check({name, "_err_valid"}, {31'd0, err_valid}, e_ev);
      check({name, "_err_addr"}, {29'd0, err_addr}, e_ea);
      check({name, "_n_access"}, log_wr.size(), exp_log.size());
      for (int j = 0; j < exp_log.size() && j < log_wr.size(); j++)
         check($sformatf("%s_access%0d", name, j),
               {7'd0, log_wr[j], 8'(log_addr[j]), log_data[j]}, exp_log[j]);
      for (int i = 0; i < int'(DEPTH); i++) begin
         exp_mem = ((i <= last_w) && (nflip[i] == 1)) ? clean[i] : stored[i];
         check($sformatf("%s_mem%0d", name, i), {16'd0, mem[i]}, {16'd0, exp_mem});
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_rd", {31'd0, mem_rd}, 32'd0);
      check("rst_wr", {31'd0, mem_wr}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_counts", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);
      check("rst_err", {28'd0, err_valid, err_addr}, 32'd0);
      check("rst_addr", {29'd0, mem_addr}, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      // clean memory, continuous grant
      gnt_mode = 0;
      for (int i = 0; i < int'(DEPTH); i++) set_word(i, 0, 0, 0);
      run_pass("clean", -1, -1);

      // directed corruptions: double at 1, single at 2 (bit 11), single in overall parity at 4
      set_word(0, 0, 0, 0); set_word(1, 2, 5, 9); set_word(2, 1, 11, 0);
      set_word(3, 0, 0, 0); set_word(4, 1, 0, 0); set_word(5, 0, 0, 0);
      run_pass("directed", -1, -1);

      // grant withheld 3 cycles on every request; a stray start mid-pass must be ignored
      gnt_mode = 2;
      set_word(0, 0, 0, 0); set_word(1, 1, 6, 0); set_word(2, 2, 3, 14);
      for (int i = 3; i < int'(DEPTH); i++) set_rand(i);
      run_pass("withheld", -1, 6);

      // abort during CHECK of a corrected word at address 1
      gnt_mode = 0;
      set_word(0, 0, 0, 0); set_word(1, 1, 13, 0);
      for (int i = 2; i < int'(DEPTH); i++) set_rand(i);
      run_pass("abort", 1, -1);

      // counter saturation with random grant
      gnt_mode = 1;
      for (int i = 0; i < 5; i++) set_word(i, 1, $urandom_range(0, 15), 0);
      set_word(5, 2, 2, 10);
      run_pass("saturate", -1, -1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < int'(DEPTH); i++) set_rand(i);
         run_pass($sformatf("rand%0d", r), -1, -1);
      end

      // reset while waiting to write back address 2
      gnt_mode = 0;
      set_word(0, 0, 0, 0); set_word(1, 0, 0, 0); set_word(2, 1, 7, 0);
      log_wr.delete(); log_addr.delete(); log_data.delete();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("rstw_req_before", {31'd0, mem_req}, 32'd1);
      check("rstw_wdata", {16'd0, wdata}, {16'd0, clean[2]});
      rst_n = 1'b0;
      #1;
      check("rstw_no_wr", {30'd0, mem_wr, mem_req}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("rstw_idle", {27'd0, busy, done, mem_req, mem_rd, mem_wr}, 32'd0);
      check("rstw_counts", {28'd0, corr_cnt, uncorr_cnt}, 32'd0);
      check("rstw_err", {28'd0, err_valid, err_addr}, 32'd0);
      check("rstw_addr", {29'd0, mem_addr}, 32'd0);
      check("rstw_n_access", log_wr.size(), 3);
      check("rstw_mem2", {16'd0, mem[2]}, {16'd0, stored[2]});
      @(posedge clk); #1 rst_n = 1'b1;

      gnt_mode = 1;
      for (int i = 0; i < int'(DEPTH); i++) set_rand(i);
      run_pass("after_rst", -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
